// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, flag bit positions and
// the flag-vector type used by the ALU output stage.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  // Bit positions inside a {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] alu_flags_t;

endpackage

// File: rtl/alu_out_fifo.sv
// alu_out_fifo: parameterised circular buffer with occupancy count.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   push       - write wr_data at the tail (ignored when full without pop)
//   pop        - retire the head entry (ignored when empty)
//   wr_data    - entry to write
//   rd_data    - head entry, reads 0 while empty
//   count      - number of occupied entries
//   full/empty - occupancy status
module alu_out_fifo #(
  parameter  int DW    = 12,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push_ok;
  logic          pop_ok;
  logic [DW-1:0] entry_data [DEPTH];

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

  // A push on a full buffer is only legal when the head leaves in the same cycle
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Data storage is not reset; emptiness masks the read port instead.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DW-1:0] data_reg;
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == PW'(gi))) begin
          data_reg <= wr_data;
        end
      end
      assign entry_data[gi] = data_reg;
    end
  endgenerate

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  assign rd_data = empty ? '0 : entry_data[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/nor8.sv
// nor8: 8-input NOR gate cell.
// Ports:
//   a - 8-bit input vector
//   y - 1 when every bit of a is 0
module nor8 (
  input  logic [7:0] a,
  output logic       y
);

  assign y = ~|a;

endmodule

// File: rtl/alu_out_stage.sv
// alu_out_stage: buffers ALU results with derived {N,Z,C,V} flags, keeps
// the accumulator and a sticky flag summary.
// Ports:
//   clk, rst_n            - clock and asynchronous active-low reset
//   in_valid/in_ready     - result input handshake
//   in_result, in_carry, in_ovf, in_acc_wr - ALU result, carry, overflow,
//                                             accumulator write request
//   out_valid/out_ready   - buffered result output handshake
//   out_result, out_flags - head entry of the buffer
//   acc                   - accumulator (operand A of the ALU)
//   sticky_flags          - OR of all accepted flags since last clear
//   sticky_clr            - synchronous clear of sticky_flags
//   count                 - occupied buffer entries
module alu_out_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_carry,
  input  logic                     in_ovf,
  input  logic                     in_acc_wr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [3:0]               out_flags,
  output logic [WIDTH-1:0]         acc,
  output logic [3:0]               sticky_flags,
  input  logic                     sticky_clr,
  output logic [$clog2(DEPTH):0]   count
);

  logic             accept;
  logic             pop;
  logic             z_flag;
  logic             fifo_full;
  logic             fifo_empty;
  alu_flags_t       in_flags;
  alu_flags_t       sticky_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH+3:0] rd_data;

  generate
    if (WIDTH == 8) begin : g_zero_nor8
      nor8 u_nor8 (
        .a (in_result),
        .y (z_flag)
      );
    end else begin : g_zero_generic
      assign z_flag = ~|in_result;
    end
  endgenerate

  always_comb begin
    in_flags         = '0;
    in_flags[FLAG_N] = in_result[WIDTH-1];
    in_flags[FLAG_Z] = z_flag;
    in_flags[FLAG_C] = in_carry;
    in_flags[FLAG_V] = in_ovf;
  end

  // When full, a consumer taking the head frees a slot in the same cycle
  assign in_ready  = !fifo_full || out_ready;
  assign out_valid = !fifo_empty;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  alu_out_fifo #(
    .DW    (WIDTH + 4),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .pop     (pop),
    .wr_data ({in_flags, in_result}),
    .rd_data (rd_data),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_result = rd_data[WIDTH-1:0];
  assign out_flags  = rd_data[WIDTH+3:WIDTH];

  // Accumulator follows accepts only, regardless of output backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (accept && in_acc_wr) begin
      acc_reg <= in_result;
    end
  end

  // Clear wins over a same-cycle OR-in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= '0;
    end else if (sticky_clr) begin
      sticky_reg <= '0;
    end else if (accept) begin
      sticky_reg <= sticky_reg | in_flags;
    end
  end

  assign acc          = acc_reg;
  assign sticky_flags = sticky_reg;

endmodule

// File: tb/tb_alu_out_stage.sv
module tb_alu_out_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_result;
    logic       in_carry;
    logic       in_ovf;
    logic       in_acc_wr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [3:0] out_flags;
    logic [7:0] acc;
    logic [3:0] sticky_flags;
    logic       sticky_clr;
    logic [1:0] count;

    int checks   = 0;
    int failures = 0;

    logic [11:0] sb[$];
    logic [7:0]  acc_exp;
    logic [3:0]  sticky_exp;

    bit          popped;
    logic [11:0] got;
    logic [11:0] exp_e;

    alu_out_stage #(.WIDTH(8), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_carry     (in_carry),
        .in_ovf       (in_ovf),
        .in_acc_wr    (in_acc_wr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .acc          (acc),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .count        (count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_flags(logic [7:0] r, logic c, logic v);
        return {r[7], (r == 8'h00), c, v};
    endfunction

    // Advance one clock: record accepts into the scoreboard / models at the
    // negedge, report what the DUT presented if a pop took place.
    task automatic cycle(output bit p, output logic [11:0] g, output logic [11:0] e);
        bit acc_now;
        logic [3:0] f;
        @(negedge clk);
        acc_now = in_valid && in_ready;
        p = out_valid && out_ready;
        g = {out_flags, out_result};
        e = 12'hxxx;
        if (p && sb.size() != 0) e = sb.pop_front();
        f = model_flags(in_result, in_carry, in_ovf);
        if (acc_now) sb.push_back({f, in_result});
        if (acc_now && in_acc_wr) acc_exp = in_result;
        if (sticky_clr) sticky_exp = 4'h0;
        else if (acc_now) sticky_exp = sticky_exp | f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_result = 8'h00; in_carry = 0; in_ovf = 0;
        in_acc_wr = 0; out_ready = 0; sticky_clr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0 || acc !== 8'h00 || sticky_flags !== 4'h0 ||
            in_ready !== 1'b1 || out_result !== 8'h00 || out_flags !== 4'h0) begin
            failures++;
            $display("FAIL reset: valid=%b count=%0d acc=%h sticky=%h ready=%b res=%h flg=%h required 0 0 00 0 1 00 0",
                     out_valid, count, acc, sticky_flags, in_ready, out_result, out_flags);
        end
        rst_n = 1;
        sb.delete(); acc_exp = 8'h00; sticky_exp = 4'h0;
        $display("reset: done");
    endtask

    task automatic test_single();
        in_valid = 1; in_result = 8'h00; in_carry = 1; out_ready = 0;
        cycle(popped, got, exp_e);
        in_valid = 0; in_carry = 0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 8'h00 || out_flags !== 4'b0110 || count !== 2'd1) begin
            failures++;
            $display("FAIL single_latency: valid=%b res=%h flg=%b count=%0d required 1 00 0110 1",
                     out_valid, out_result, out_flags, count);
        end
        out_ready = 1;
        cycle(popped, got, exp_e);
        checks++;
        if (!popped || got !== exp_e) begin
            failures++;
            $display("FAIL single_pop: popped=%b got=%h required %h", popped, got, exp_e);
        end
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || out_result !== 8'h00 || out_flags !== 4'h0) begin
            failures++;
            $display("FAIL single_empty: count=%0d valid=%b res=%h flg=%h required 0 0 00 0",
                     count, out_valid, out_result, out_flags);
        end
        out_ready = 0;
        $display("single: popped %h", got);
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        in_valid = 1; in_result = 8'h81;
        cycle(popped, got, exp_e);
        in_result = 8'h7F;
        cycle(popped, got, exp_e);
        checks++;
        if (count !== 2'd2 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full: count=%0d in_ready=%b required 2 0", count, in_ready);
        end
        in_result = 8'hAA;
        cycle(popped, got, exp_e);
        checks++;
        if (count !== 2'd2 || out_result !== 8'h81 || out_flags[3] !== 1'b1 || out_flags !== 4'b1000) begin
            failures++;
            $display("FAIL bp_stall: count=%0d head=%h flg=%b required 2 81 1000", count, out_result, out_flags);
        end
        $display("backpressure: head %h count %0d", out_result, count);
    endtask

    task automatic test_pass_through();
        in_valid = 1; in_result = 8'h55; out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL pt_ready: in_ready=%b required 1", in_ready);
        end
        cycle(popped, got, exp_e);
        in_valid = 0;
        checks++;
        if (!popped || got !== exp_e || got[7:0] !== 8'h81 || count !== 2'd2) begin
            failures++;
            $display("FAIL pt_swap: got=%h required %h (81), count=%0d required 2", got, exp_e, count);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(popped, got, exp_e);
            checks++;
            if (!popped || got !== exp_e) begin
                failures++;
                $display("FAIL pt_order%0d: got=%h required %h", i, got, exp_e);
            end
            $display("pass_through: popped %h", got[7:0]);
        end
        out_ready = 0;
    endtask

    task automatic test_acc();
        out_ready = 0;
        in_valid = 1; in_result = 8'h3C; in_acc_wr = 1;
        cycle(popped, got, exp_e);
        checks++;
        if (acc !== 8'h3C) begin
            failures++;
            $display("FAIL acc_load: acc=%h required 3c", acc);
        end
        in_result = 8'h11; in_acc_wr = 0;
        cycle(popped, got, exp_e);
        checks++;
        if (acc !== acc_exp || acc !== 8'h3C) begin
            failures++;
            $display("FAIL acc_hold: acc=%h required %h", acc, acc_exp);
        end
        in_valid = 1; in_result = 8'h99; in_acc_wr = 1;
        cycle(popped, got, exp_e);
        checks++;
        if (acc !== 8'h3C) begin
            failures++;
            $display("FAIL acc_noaccept: acc=%h required 3c", acc);
        end
        in_valid = 0; in_acc_wr = 0; out_ready = 1;
        for (int i = 0; i < 2; i++) begin
            cycle(popped, got, exp_e);
            checks++;
            if (!popped || got !== exp_e) begin
                failures++;
                $display("FAIL acc_drain%0d: got=%h required %h", i, got, exp_e);
            end
        end
        out_ready = 0;
        $display("acc: acc=%h", acc);
    endtask

    task automatic test_sticky();
        out_ready = 1;
        sticky_clr = 1;
        cycle(popped, got, exp_e);
        sticky_clr = 0;
        in_valid = 1; in_result = 8'h01; in_ovf = 1;
        cycle(popped, got, exp_e);
        checks++;
        if (sticky_flags !== 4'b0001) begin
            failures++;
            $display("FAIL sticky_or: sticky=%b required 0001", sticky_flags);
        end
        in_result = 8'h80; in_ovf = 0; sticky_clr = 1;
        cycle(popped, got, exp_e);
        checks++;
        if (sticky_flags !== 4'b0000) begin
            failures++;
            $display("FAIL sticky_clr_prio: sticky=%b required 0000", sticky_flags);
        end
        sticky_clr = 0; in_result = 8'h00; in_carry = 1;
        cycle(popped, got, exp_e);
        in_valid = 0; in_carry = 0;
        checks++;
        if (sticky_flags !== 4'b0110 || sticky_flags !== sticky_exp) begin
            failures++;
            $display("FAIL sticky_zc: sticky=%b required 0110", sticky_flags);
        end
        for (int i = 0; i < 4 && sb.size() != 0; i++) begin
            cycle(popped, got, exp_e);
            checks++;
            if (!popped || got !== exp_e) begin
                failures++;
                $display("FAIL sticky_drain%0d: got=%h required %h", i, got, exp_e);
            end
        end
        out_ready = 0;
        $display("sticky: %b", sticky_flags);
    endtask

    task automatic test_async_reset();
        out_ready = 0; in_valid = 1; in_acc_wr = 1; in_result = 8'hC3;
        cycle(popped, got, exp_e);
        in_result = 8'h24;
        cycle(popped, got, exp_e);
        in_valid = 0; in_acc_wr = 0;
        checks++;
        if (count !== 2'd2) begin
            failures++;
            $display("FAIL ar_fill: count=%0d required 2", count);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0 || acc !== 8'h00 || in_ready !== 1'b1 || out_result !== 8'h00) begin
            failures++;
            $display("FAIL async_reset: valid=%b count=%0d acc=%h ready=%b res=%h required 0 0 00 1 00",
                     out_valid, count, acc, in_ready, out_result);
        end
        sb.delete(); acc_exp = 8'h00; sticky_exp = 4'h0;
        @(posedge clk);
        #1 rst_n = 1;
        in_valid = 1; in_result = 8'hE7;
        cycle(popped, got, exp_e);
        in_valid = 0;
        checks++;
        if (count !== 2'd1 || out_result !== 8'hE7 || out_flags !== 4'b1000) begin
            failures++;
            $display("FAIL ar_restart: count=%0d res=%h flg=%b required 1 e7 1000", count, out_result, out_flags);
        end
        out_ready = 1;
        cycle(popped, got, exp_e);
        checks++;
        if (!popped || got !== exp_e) begin
            failures++;
            $display("FAIL ar_pop: got=%h required %h", got, exp_e);
        end
        out_ready = 0;
        $display("async_reset: restart popped %h", got[7:0]);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 150; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_result  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) in_result = 8'h00;
            in_carry   = 1'($urandom_range(0, 1));
            in_ovf     = 1'($urandom_range(0, 1));
            in_acc_wr  = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 2) != 0);
            sticky_clr = ($urandom_range(0, 7) == 0);
            cycle(popped, got, exp_e);
            if (popped) begin
                checks++;
                if (got !== exp_e) begin
                    failures++;
                    $display("FAIL b2b_data%0d: got=%h required %h", n, got, exp_e);
                end
            end
            checks++;
            if (count !== 2'(sb.size()) || acc !== acc_exp || sticky_flags !== sticky_exp) begin
                failures++;
                $display("FAIL b2b_state%0d: count=%0d acc=%h sticky=%b required %0d %h %b",
                         n, count, acc, sticky_flags, sb.size(), acc_exp, sticky_exp);
            end
        end
        in_valid = 0; sticky_clr = 0; out_ready = 1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            cycle(popped, got, exp_e);
            checks++;
            if (!popped || got !== exp_e) begin
                failures++;
                $display("FAIL b2b_drain%0d: got=%h required %h", i, got, exp_e);
            end
        end
        checks++;
        if (count !== 2'd0 || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_final: count=%0d queue=%0d required 0 0", count, sb.size());
        end
        out_ready = 0;
        $display("back_to_back: done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_pass_through();
        test_acc();
        test_sticky();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_out_stage.md
ALU_OUT_STAGE -- requirements
Module: alu_out_stage

Interface
REQ-001 Parameter: WIDTH, 8, ALU result width in bits.
REQ-002 Parameter: DEPTH, 2, output buffer entries; power of two, 2..8.
REQ-003 Port: clk  input  1  sole clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  ALU result valid this cycle.
REQ-006 Port: in_ready  output  1  stage can accept a result.
REQ-007 Port: in_result  input  WIDTH  ALU result word.
REQ-008 Port: in_carry  input  1  ALU carry-out.
REQ-009 Port: in_ovf  input  1  ALU signed overflow.
REQ-010 Port: in_acc_wr  input  1  also load result into accumulator.
REQ-011 Port: out_valid  output  1  buffered result available.
REQ-012 Port: out_ready  input  1  consumer takes head entry.
REQ-013 Port: out_result  output  WIDTH  head entry result.
REQ-014 Port: out_flags  output  4  head entry flags {N,Z,C,V}.
REQ-015 Port: acc  output  WIDTH  accumulator, feeds ALU operand A.
REQ-016 Port: sticky_flags  output  4  OR of all accepted {N,Z,C,V} since clear.
REQ-017 Port: sticky_clr  input  1  synchronous clear of sticky_flags.
REQ-018 Port: count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-019 Accept occurs when in_valid and in_ready are both 1; push occurs only on accept.
REQ-020 Pop occurs when out_valid and out_ready are both 1.
REQ-021 in_ready SHALL be 1 when count < DEPTH, or when count == DEPTH and out_ready is 1 (full pass-through).
REQ-022 out_valid SHALL equal (count != 0); out_result/out_flags are registered buffer contents, never combinational from inputs.
REQ-023 Latency in to out SHALL be exactly 1 cycle when the buffer is empty.
REQ-024 Flags computed at accept: N = in_result[WIDTH-1]; Z = NOR of all in_result bits; C = in_carry; V = in_ovf.
REQ-025 Buffer SHALL be a circular FIFO with read/write pointers wrapping modulo DEPTH; ordering strictly preserved.
REQ-026 Simultaneous push and pop: count unchanged; on empty buffer, pop is impossible, entry is written and count becomes 1.
REQ-027 Pop on empty or push on full without pop SHALL never occur, since handshakes gate them; state unchanged.
REQ-028 acc SHALL load in_result on accept with in_acc_wr = 1; otherwise hold; acc update is independent of output backpressure.
REQ-029 sticky_flags SHALL OR in each accepted entry's flags; sticky_clr has priority over same-cycle OR-in, and the result is 0.
REQ-030 out_result/out_flags SHALL hold stable while out_valid = 1 and out_ready = 0.

Reset
REQ-031 rst_n low SHALL asynchronously force count = 0, pointers = 0, out_valid = 0, acc = 0, and sticky_flags = 0; in_ready = 1 during reset.
REQ-032 Buffer data storage need not be reset; out_result/out_flags SHALL read 0 while count = 0.
REQ-033 Reset assertion mid-transfer SHALL discard all buffered entries; the first accept after deassertion behaves as from empty.

Structure
REQ-034 Shared package alu_pkg SHALL hold the WIDTH default, flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), and the flags typedef.
REQ-035 Zero flag SHALL reuse the existing nor8 gate cell when WIDTH = 8.
REQ-036 One sub-module, alu_out_fifo (parameterised circular buffer with count), SHALL be instantiated; flag logic and accumulator stay in the top.

Verification
REQ-037 Reset then single accept of 0x00, carry 1 -> next cycle out_valid = 1, out_result = 0x00, out_flags = 4'b0110, count = 1.
REQ-038 out_ready = 0; push 0x81, 0x7F -> count = 2, in_ready = 0; third in_valid stalls; head stays 0x81, flags N=1.
REQ-039 Full, then in_valid and out_ready both 1 with 0x55 -> pop 0x81, push 0x55, count stays 2; order 0x7F, 0x55.
REQ-040 Accept 0x3C with in_acc_wr = 1 while output backpressured -> acc = 0x3C next cycle.
REQ-041 Accept V=1 result, then sticky_clr and accept of 0x80 in same cycle -> sticky_flags = 0 next cycle.
REQ-042 rst_n low asynchronously with 2 entries -> out_valid = 0 and count = 0 immediately, without a clock edge; acc = 0.
